can_tx_sched: RTL and testbench
===============================

CAN_TX_SCHED -- requirements
Module: can_tx_sched

Interface
Parameters:
REQ-001 BIT_TICKS, default 200, CLK cycles per CAN bit time.
REQ-002 IDLE_BITS, default 11, consecutive recessive bits that declare the bus idle.
REQ-003 NREQ, default 4, number of requesters (mailboxes).
REQ-004 RETRY_MAX, default 3, error retries per request before abort.
Ports (one clock; reset asynchronous, active-low):
REQ-005 CLK  in  1  system clock.
REQ-006 RST_N  in  1  asynchronous active-low reset.
REQ-007 RX  in  1  CAN bus receive level (0 = dominant).
REQ-008 REQ  in  NREQ  per-mailbox transmit request, level-held.
REQ-009 SER_DONE  in  1  serializer pulse: frame sent and acknowledged.
REQ-010 SER_ARB_LOST  in  1  serializer pulse: arbitration lost.
REQ-011 SER_ERR  in  1  serializer pulse: bit or ACK error.
REQ-012 GNT  out  NREQ  one-hot grant to the serializer, held for the whole frame.
REQ-013 START  out  1  one-cycle pulse telling the serializer to begin SOF.
REQ-014 BIT_TICK  out  1  one-cycle strobe at the sample point (BIT_TICKS/2) of each bit.
REQ-015 BUS_IDLE  out  1  bus-idle flag.
REQ-016 DONE  out  NREQ  one-cycle per-mailbox success pulse.
REQ-017 ABORT  out  NREQ  one-cycle per-mailbox abort pulse after the retry limit.

Function
REQ-018 Bit counter counts 0..BIT_TICKS-1 and wraps; a registered RX falling edge (recessive-to-dominant) reloads it to 0 (hard sync) in every state.
REQ-019 BIT_TICK asserts for exactly one cycle when the bit counter equals BIT_TICKS/2 - 1.
REQ-020 Recessive counter increments on BIT_TICK when RX=1, saturates at IDLE_BITS, and clears on BIT_TICK when RX=0.
REQ-021 BUS_IDLE = (recessive counter == IDLE_BITS); it is combinationally derived from the register.
REQ-022 FSM states: WAIT_IDLE, ARB, LAUNCH, BUSY.
REQ-023 WAIT_IDLE -> ARB when BUS_IDLE=1 and REQ is nonzero, excluding slots masked by an ABORT in the same cycle.
REQ-024 ARB registers GNT as one-hot of the lowest-index set REQ bit (fixed priority; index 0 is highest) and goes to LAUNCH next cycle; if REQ is zero in ARB, it returns to WAIT_IDLE with GNT=0.
REQ-025 LAUNCH asserts START for one cycle, then goes to BUSY; GNT stays stable from LAUNCH through the BUSY exit.
REQ-026 In BUSY, REQ changes are ignored; the grant remains latched.
REQ-027 In BUSY, if several outcome pulses arrive in the same cycle, priority is SER_ERR > SER_ARB_LOST > SER_DONE.
REQ-028 SER_DONE: DONE[g] pulses for one cycle the next cycle, the retry counter of g clears, GNT clears, and the FSM goes to WAIT_IDLE.
REQ-029 SER_ARB_LOST: GNT clears, the retry count is unchanged, and the FSM goes to WAIT_IDLE; the request is re-arbitrated at the next idle.
REQ-030 SER_ERR: the retry counter of g increments; if the new value exceeds RETRY_MAX, ABORT[g] pulses for one cycle and the counter clears; GNT clears and the FSM goes to WAIT_IDLE.
REQ-031 An aborted slot is not granted again until its REQ has been observed at 0 for at least one cycle.
REQ-032 Entering WAIT_IDLE from BUSY forces the recessive counter to 0, so the bus-idle qualification restarts.
REQ-033 Retry counters are ceil(log2(RETRY_MAX+2)) bits wide, one per slot.

Reset
REQ-034 While RST_N=0: FSM=WAIT_IDLE; bit counter, recessive counter, and retry counters = 0; abort masks cleared.
REQ-035 While RST_N=0: GNT, START, BIT_TICK, BUS_IDLE, DONE, ABORT = 0.
REQ-036 Reset asserted mid-frame drops GNT immediately (asynchronously), with no DONE or ABORT pulse.

Verification
REQ-037 RX=1 held, REQ=0101 from reset -> BUS_IDLE rises after 11 bits (≈11×200 cycles); GNT=0001 one cycle after ARB; START pulses once; then SER_DONE -> DONE=0001 pulse and the FSM returns to WAIT_IDLE.
REQ-038 RX held 0 with REQ=0001 -> BUS_IDLE stays 0, START never asserts, and BIT_TICK period = 200 cycles.
REQ-039 Grant slot 2, inject SER_ERR four times with RETRY_MAX=3 -> ABORT=0100 on the 4th error; no further grant to slot 2 until REQ[2] toggles low.
REQ-040 Grant slot 1, inject SER_ERR and SER_DONE in the same cycle -> error path taken, retry=1, no DONE pulse.
REQ-041 Inject an RX falling edge at bit counter = 150 -> counter reloads to 0; next BIT_TICK comes 99 cycles later.
REQ-042 Drive RST_N low during BUSY with GNT=1000 -> GNT=0 immediately; after release, full idle qualification is required before a new START.

Source files
------------

// File: rtl/can_tx_sched.sv
// CAN transmit scheduler: bit timing with hard sync, bus-idle detection and
// fixed-priority mailbox arbitration with per-slot retry/abort handling.
module can_tx_sched #(
    parameter int BIT_TICKS = 200,
    parameter int IDLE_BITS = 11,
    parameter int NREQ      = 4,
    parameter int RETRY_MAX = 3
) (
    input  logic            CLK,
    input  logic            RST_N,
    input  logic            RX,
    input  logic [NREQ-1:0] REQ,
    input  logic            SER_DONE,
    input  logic            SER_ARB_LOST,
    input  logic            SER_ERR,
    output logic [NREQ-1:0] GNT,
    output logic            START,
    output logic            BIT_TICK,
    output logic            BUS_IDLE,
    output logic [NREQ-1:0] DONE,
    output logic [NREQ-1:0] ABORT
);

    localparam int CW = (BIT_TICKS > 1) ? $clog2(BIT_TICKS) : 1;
    localparam int IW = $clog2(IDLE_BITS + 1);
    localparam int RW = $clog2(RETRY_MAX + 2);
    localparam int GW = (NREQ > 1) ? $clog2(NREQ) : 1;

    localparam logic [CW-1:0] TICK_LAST  = CW'(BIT_TICKS - 1);
    localparam logic [CW-1:0] SAMPLE_PT  = CW'(BIT_TICKS / 2 - 1);
    localparam logic [IW-1:0] IDLE_FULL  = IW'(IDLE_BITS);
    localparam logic [RW-1:0] RETRY_LIM  = RW'(RETRY_MAX);

    typedef enum logic [1:0] {
        WAIT_IDLE = 2'd0,
        ARB       = 2'd1,
        LAUNCH    = 2'd2,
        BUSY      = 2'd3
    } state_t;

    function automatic logic [NREQ-1:0] lowest_set(input logic [NREQ-1:0] v);
        return v & (~v + NREQ'(1));
    endfunction

    function automatic logic [GW-1:0] onehot_idx(input logic [NREQ-1:0] oh);
        logic [GW-1:0] idx;
        idx = {GW{1'b0}};
        for (int i = 0; i < NREQ; i++) begin
            idx = idx | ({GW{oh[i]}} & GW'(i));
        end
        return idx;
    endfunction

    state_t          state_q, state_d;
    logic            rx_q;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [IW-1:0]   rec_q, rec_d;
    logic [NREQ-1:0] gnt_q, gnt_d;
    logic            start_q, start_d;
    logic [NREQ-1:0] done_q, done_d;
    logic [NREQ-1:0] abort_q, abort_d;
    logic [NREQ-1:0] mask_q, mask_d;
    logic [RW-1:0]   retry_q [NREQ];
    logic [RW-1:0]   retry_d [NREQ];

    logic            fall_s;
    logic            rec_clr_s;
    logic [NREQ-1:0] eligible_s;
    logic [GW-1:0]   gidx_s;
    logic [RW-1:0]   retry_inc_s;

    assign fall_s      = rx_q & ~RX;
    assign BIT_TICK    = (cnt_q == SAMPLE_PT);
    assign BUS_IDLE    = (rec_q == IDLE_FULL);
    assign eligible_s  = REQ & ~mask_q;
    assign gidx_s      = onehot_idx(gnt_q);
    assign retry_inc_s = retry_q[gidx_s] + RW'(1);

    assign GNT   = gnt_q;
    assign START = start_q;
    assign DONE  = done_q;
    assign ABORT = abort_q;

    // Bit-time counter with hard resync on every recessive-to-dominant edge.
    always_comb begin
        cnt_d = cnt_q;
        if (fall_s) begin
            cnt_d = {CW{1'b0}};
        end else if (cnt_q == TICK_LAST) begin
            cnt_d = {CW{1'b0}};
        end else begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    // Recessive-bit counter; restarts whenever a frame attempt finishes.
    always_comb begin
        rec_d = rec_q;
        if (rec_clr_s) begin
            rec_d = {IW{1'b0}};
        end else if (BIT_TICK) begin
            if (!rx_q) begin
                rec_d = {IW{1'b0}};
            end else if (rec_q == IDLE_FULL) begin
                rec_d = rec_q;
            end else begin
                rec_d = rec_q + IW'(1);
            end
        end else begin
            rec_d = rec_q;
        end
    end

    // Scheduler FSM: arbitration, launch and outcome handling.
    always_comb begin
        state_d   = state_q;
        gnt_d     = gnt_q;
        start_d   = 1'b0;
        done_d    = {NREQ{1'b0}};
        abort_d   = {NREQ{1'b0}};
        mask_d    = mask_q & REQ;   // a mask drops once its request is seen low
        retry_d   = retry_q;
        rec_clr_s = 1'b0;
        case (state_q)
            WAIT_IDLE: begin
                if (BUS_IDLE && (|eligible_s)) begin
                    state_d = ARB;
                end else begin
                    state_d = WAIT_IDLE;
                end
            end
            ARB: begin
                if (|eligible_s) begin
                    gnt_d   = lowest_set(eligible_s);
                    start_d = 1'b1;
                    state_d = LAUNCH;
                end else begin
                    gnt_d   = {NREQ{1'b0}};
                    state_d = WAIT_IDLE;
                end
            end
            LAUNCH: begin
                state_d = BUSY;
            end
            BUSY: begin
                if (SER_ERR) begin
                    if (retry_inc_s > RETRY_LIM) begin
                        abort_d         = gnt_q;
                        mask_d          = mask_d | gnt_q;
                        retry_d[gidx_s] = {RW{1'b0}};
                    end else begin
                        retry_d[gidx_s] = retry_inc_s;
                    end
                    gnt_d     = {NREQ{1'b0}};
                    rec_clr_s = 1'b1;
                    state_d   = WAIT_IDLE;
                end else if (SER_ARB_LOST) begin
                    gnt_d     = {NREQ{1'b0}};
                    rec_clr_s = 1'b1;
                    state_d   = WAIT_IDLE;
                end else if (SER_DONE) begin
                    done_d          = gnt_q;
                    retry_d[gidx_s] = {RW{1'b0}};
                    gnt_d           = {NREQ{1'b0}};
                    rec_clr_s       = 1'b1;
                    state_d         = WAIT_IDLE;
                end else begin
                    state_d = BUSY;
                end
            end
            default: begin
                gnt_d   = {NREQ{1'b0}};
                state_d = WAIT_IDLE;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= WAIT_IDLE;
            rx_q    <= 1'b1;
            cnt_q   <= {CW{1'b0}};
            rec_q   <= {IW{1'b0}};
            gnt_q   <= {NREQ{1'b0}};
            start_q <= 1'b0;
            done_q  <= {NREQ{1'b0}};
            abort_q <= {NREQ{1'b0}};
            mask_q  <= {NREQ{1'b0}};
            for (int i = 0; i < NREQ; i++) begin
                retry_q[i] <= {RW{1'b0}};
            end
        end else begin
            state_q <= state_d;
            rx_q    <= RX;
            cnt_q   <= cnt_d;
            rec_q   <= rec_d;
            gnt_q   <= gnt_d;
            start_q <= start_d;
            done_q  <= done_d;
            abort_q <= abort_d;
            mask_q  <= mask_d;
            for (int i = 0; i < NREQ; i++) begin
                retry_q[i] <= retry_d[i];
            end
        end
    end

endmodule

// File: tb/tb_can_tx_sched.sv
// Directed self-checking bench for can_tx_sched with default parameters.
module tb_can_tx_sched;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       rx;
    logic [3:0] req;
    logic       ser_done, ser_arb_lost, ser_err;
    logic [3:0] gnt, done, abort;
    logic       start, bit_tick, bus_idle;

    int n_chk = 0;
    int n_err = 0;

    can_tx_sched #(
        .BIT_TICKS(200), .IDLE_BITS(11), .NREQ(4), .RETRY_MAX(3)
    ) dut (
        .CLK(clk), .RST_N(rst_n), .RX(rx), .REQ(req),
        .SER_DONE(ser_done), .SER_ARB_LOST(ser_arb_lost), .SER_ERR(ser_err),
        .GNT(gnt), .START(start), .BIT_TICK(bit_tick), .BUS_IDLE(bus_idle),
        .DONE(done), .ABORT(abort)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic wait_start(input int bound, input string tag);
        int c;
        c = 0;
        while (!start && c < bound) begin
            @(negedge clk);
            c++;
        end
        chk(tag, {31'd0, start}, 32'd1);
    endtask

    task automatic outcome(input logic e, input logic a, input logic d);
        ser_err = e; ser_arb_lost = a; ser_done = d;
        @(negedge clk);
        ser_err = 1'b0; ser_arb_lost = 1'b0; ser_done = 1'b0;
    endtask

    task automatic grant_and_hit(input string tag, input logic [3:0] exp_gnt,
                                 input logic e, input logic a, input logic d,
                                 input logic [3:0] exp_done, input logic [3:0] exp_abort);
        wait_start(3000, {tag, "_start"});
        chk({tag, "_gnt"}, {28'd0, gnt}, {28'd0, exp_gnt});
        @(negedge clk);
        chk({tag, "_start_once"}, {31'd0, start}, 32'd0);
        outcome(e, a, d);
        chk({tag, "_done"}, {28'd0, done}, {28'd0, exp_done});
        chk({tag, "_abort"}, {28'd0, abort}, {28'd0, exp_abort});
        chk({tag, "_gnt_clr"}, {28'd0, gnt}, 32'd0);
    endtask

    initial begin
        int ticks, c, st, id, last, period, n;
        rst_n = 1'b0; rx = 1'b1; req = 4'b0000;
        ser_done = 1'b0; ser_arb_lost = 1'b0; ser_err = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_gnt",   {28'd0, gnt},   32'd0);
        chk("rst_start", {31'd0, start}, 32'd0);
        chk("rst_tick",  {31'd0, bit_tick}, 32'd0);
        chk("rst_idle",  {31'd0, bus_idle}, 32'd0);
        chk("rst_done",  {28'd0, done},  32'd0);
        chk("rst_abort", {28'd0, abort}, 32'd0);

        // idle qualification, fixed priority, single START, success
        rst_n = 1'b1; req = 4'b0101;
        ticks = 0; c = 0;
        while (!bus_idle && c < 3000) begin
            @(negedge clk);
            c++;
            if (bit_tick) ticks++;
        end
        chk("idle_rise", {31'd0, bus_idle}, 32'd1);
        chk("idle_bits", ticks, 32'd11);
        wait_start(10, "t1_start");
        chk("t1_gnt", {28'd0, gnt}, 32'h1);
        @(negedge clk);
        chk("t1_start_once", {31'd0, start}, 32'd0);
        req = 4'b0000;
        @(negedge clk);
        chk("t1_gnt_hold", {28'd0, gnt}, 32'h1);
        outcome(1'b0, 1'b0, 1'b1);
        chk("t1_done", {28'd0, done}, 32'h1);
        chk("t1_gnt_clr", {28'd0, gnt}, 32'd0);
        @(negedge clk);
        chk("t1_done_pulse", {28'd0, done}, 32'd0);
        chk("t1_idle_restart", {31'd0, bus_idle}, 32'd0);

        // dominant bus: never idle, never start, bit period unchanged
        req = 4'b0001; rx = 1'b0;
        st = 0; id = 0; last = 0; period = 0;
        for (int i = 1; i <= 1000; i++) begin
            @(negedge clk);
            if (start) st++;
            if (bus_idle) id++;
            if (bit_tick) begin
                if (last > 0) period = i - last;
                last = i;
            end
        end
        chk("dom_no_start", st, 32'd0);
        chk("dom_no_idle", id, 32'd0);
        chk("dom_period", period, 32'd200);
        req = 4'b0000;
        @(negedge clk);
        rx = 1'b1;

        // hard sync: falling edge at counter 150
        c = 0;
        while (!bit_tick && c < 300) begin
            @(negedge clk);
            c++;
        end
        chk("sync_tick_seen", {31'd0, bit_tick}, 32'd1);
        repeat (51) @(negedge clk);
        rx = 1'b0;
        @(negedge clk);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!bit_tick && n < 300);
        chk("sync_gap", n, 32'd99);
        rx = 1'b1;

        // slot 2: four errors abort, masked until REQ drops
        req = 4'b0100;
        for (int i = 0; i < 4; i++) begin
            grant_and_hit("s2_err", 4'b0100, 1'b1, 1'b0, 1'b0, 4'b0000,
                          (i == 3) ? 4'b0100 : 4'b0000);
        end
        @(negedge clk);
        chk("s2_abort_pulse", {28'd0, abort}, 32'd0);
        st = 0;
        repeat (3000) begin
            @(negedge clk);
            if (start) st++;
        end
        chk("s2_masked", st, 32'd0);
        chk("s2_idle_avail", {31'd0, bus_idle}, 32'd1);
        req = 4'b0000;
        @(negedge clk);
        req = 4'b0100;
        wait_start(10, "s2_regrant");
        chk("s2_regrant_gnt", {28'd0, gnt}, 32'h4);
        @(negedge clk);
        outcome(1'b0, 1'b0, 1'b1);
        chk("s2_done", {28'd0, done}, 32'h4);
        req = 4'b0000;

        // slot 1: outcome priorities and retry accounting
        req = 4'b0010;
        grant_and_hit("s1_err_done", 4'b0010, 1'b1, 1'b0, 1'b1, 4'b0000, 4'b0000);
        grant_and_hit("s1_err2",     4'b0010, 1'b1, 1'b0, 1'b0, 4'b0000, 4'b0000);
        grant_and_hit("s1_lost",     4'b0010, 1'b0, 1'b1, 1'b1, 4'b0000, 4'b0000);
        grant_and_hit("s1_err3",     4'b0010, 1'b1, 1'b0, 1'b0, 4'b0000, 4'b0000);
        grant_and_hit("s1_err4",     4'b0010, 1'b1, 1'b0, 1'b0, 4'b0000, 4'b0010);
        req = 4'b0000;

        // reset during a frame
        @(negedge clk);
        req = 4'b1000;
        wait_start(3000, "r_start");
        chk("r_gnt", {28'd0, gnt}, 32'h8);
        @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("r_gnt_async", {28'd0, gnt}, 32'd0);
        chk("r_no_done", {28'd0, done}, 32'd0);
        chk("r_no_abort", {28'd0, abort}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        st = 0;
        repeat (2000) begin
            @(negedge clk);
            if (start) st++;
        end
        chk("r_requalify", st, 32'd0);
        wait_start(500, "r_restart");
        chk("r_regnt", {28'd0, gnt}, 32'h8);
        @(negedge clk);
        outcome(1'b0, 1'b0, 1'b1);
        chk("r_done", {28'd0, done}, 32'h8);
        req = 4'b0000;

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
